// File: rtl/tub_frame_sched.sv
// Frame scheduler for the tube display: background, timed status and blinking timed alert
// channels, each with its own buffer, merged by priority into one registered output frame.
module tub_frame_sched #(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned HOLD_MS  = 2000,
  parameter int unsigned BLINK_MS = 250
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        bg_load,
  input  logic [63:0] bg_frame,
  input  logic        st_load,
  input  logic [63:0] st_frame,
  input  logic        al_load,
  input  logic [63:0] al_frame,
  input  logic        abort,
  output logic [63:0] out_frame,
  output logic [1:0]  active_src,
  output logic        busy
);

  localparam int unsigned N  = HOLD_MS * TICK_DIV;
  localparam int unsigned B  = BLINK_MS * TICK_DIV;
  localparam int          CW = $clog2(N + 1);
  localparam int          BW = (B > 1) ? $clog2(B) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(N);
  localparam logic [BW-1:0] BLINK_LAST = BW'(B - 1);

  typedef enum logic [1:0] {
    SRC_BG = 2'd0,
    SRC_ST = 2'd1,
    SRC_AL = 2'd2
  } src_e;

  logic [63:0]   bg_buf_q, bg_buf_d;
  logic [63:0]   st_buf_q, st_buf_d;
  logic [63:0]   al_buf_q, al_buf_d;
  logic [CW-1:0] st_cnt_q, st_cnt_d;
  logic [CW-1:0] al_cnt_q, al_cnt_d;
  logic          st_act_q, st_act_d;
  logic          al_act_q, al_act_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;
  logic [63:0]   out_frame_q, out_frame_d;
  src_e          src_q, src_d;
  logic          busy_q, busy_d;

  // Frame buffers: each one only follows its own load strobe, abort does not block the write.
  always_comb begin
    bg_buf_d = bg_buf_q;
    st_buf_d = st_buf_q;
    al_buf_d = al_buf_q;
    if (bg_load) begin
      bg_buf_d = bg_frame;
    end else begin
      bg_buf_d = bg_buf_q;
    end
    if (st_load) begin
      st_buf_d = st_frame;
    end else begin
      st_buf_d = st_buf_q;
    end
    if (al_load) begin
      al_buf_d = al_frame;
    end else begin
      al_buf_d = al_buf_q;
    end
  end

  // Status hold timer: load restarts at cycle 0, last active cycle is N-1, count saturates at N.
  always_comb begin
    st_cnt_d = st_cnt_q;
    st_act_d = st_act_q;
    if (abort) begin
      st_cnt_d = '0;
      st_act_d = 1'b0;
    end else if (st_load) begin
      st_cnt_d = '0;
      st_act_d = 1'b1;
    end else if (st_act_q) begin
      if (st_cnt_q != CNT_SAT) begin
        st_cnt_d = st_cnt_q + CW'(1);
      end else begin
        st_cnt_d = st_cnt_q;
      end
      if (st_cnt_q == CNT_LAST) begin
        st_act_d = 1'b0;
      end else begin
        st_act_d = 1'b1;
      end
    end else begin
      st_cnt_d = st_cnt_q;
      st_act_d = 1'b0;
    end
  end

  // Alert hold timer plus blink phase; every load restarts in the visible half.
  always_comb begin
    al_cnt_d    = al_cnt_q;
    al_act_d    = al_act_q;
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (abort) begin
      al_cnt_d    = '0;
      al_act_d    = 1'b0;
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (al_load) begin
      al_cnt_d    = '0;
      al_act_d    = 1'b1;
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (al_act_q) begin
      if (al_cnt_q != CNT_SAT) begin
        al_cnt_d = al_cnt_q + CW'(1);
      end else begin
        al_cnt_d = al_cnt_q;
      end
      if (al_cnt_q == CNT_LAST) begin
        al_act_d = 1'b0;
      end else begin
        al_act_d = 1'b1;
      end
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
        blank_d     = blank_q;
      end
    end else begin
      al_cnt_d    = al_cnt_q;
      al_act_d    = 1'b0;
      blink_cnt_d = blink_cnt_q;
      blank_d     = blank_q;
    end
  end

  // Output selection from registered channel state, so outputs trail channel changes by one cycle.
  always_comb begin
    out_frame_d = bg_buf_q;
    src_d       = SRC_BG;
    busy_d      = st_act_q | al_act_q;
    case ({al_act_q, st_act_q})
      2'b10, 2'b11: begin
        out_frame_d = blank_q ? 64'h0 : al_buf_q;
        src_d       = SRC_AL;
      end
      2'b01: begin
        out_frame_d = st_buf_q;
        src_d       = SRC_ST;
      end
      2'b00: begin
        out_frame_d = bg_buf_q;
        src_d       = SRC_BG;
      end
      default: begin
        out_frame_d = bg_buf_q;
        src_d       = SRC_BG;
      end
    endcase
  end

  // State and output registers, cleared asynchronously so a reset drops any hold in progress.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      bg_buf_q    <= 64'h0;
      st_buf_q    <= 64'h0;
      al_buf_q    <= 64'h0;
      st_cnt_q    <= '0;
      al_cnt_q    <= '0;
      st_act_q    <= 1'b0;
      al_act_q    <= 1'b0;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      out_frame_q <= 64'h0;
      src_q       <= SRC_BG;
      busy_q      <= 1'b0;
    end else begin
      bg_buf_q    <= bg_buf_d;
      st_buf_q    <= st_buf_d;
      al_buf_q    <= al_buf_d;
      st_cnt_q    <= st_cnt_d;
      al_cnt_q    <= al_cnt_d;
      st_act_q    <= st_act_d;
      al_act_q    <= al_act_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      out_frame_q <= out_frame_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
    end
  end

  assign out_frame  = out_frame_q;
  assign active_src = src_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_tub_frame_sched.sv
// Bench for tub_frame_sched: directed scenarios then random loads, all checked each cycle
// against a timestamp-based model of the hold and blink rules.
module tb_tub_frame_sched;
  localparam int TICK_DIV = 4;
  localparam int HOLD_MS  = 3;
  localparam int BLINK_MS = 1;
  localparam int N = HOLD_MS * TICK_DIV;
  localparam int B = BLINK_MS * TICK_DIV;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        bg_load, st_load, al_load, abort;
  logic [63:0] bg_frame, st_frame, al_frame;
  logic [63:0] out_frame;
  logic [1:0]  active_src;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: edge index, start edge of each timed channel, buffers, pending outputs
  int          e;
  int          st_start, al_start;
  bit          st_valid, al_valid;
  logic [63:0] m_bg, m_st, m_al;
  logic [63:0] pend_out, cur_out;
  logic [1:0]  pend_src, cur_src;
  logic        pend_busy, cur_busy;

  tub_frame_sched #(.TICK_DIV(TICK_DIV), .HOLD_MS(HOLD_MS), .BLINK_MS(BLINK_MS)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .bg_load(bg_load), .bg_frame(bg_frame),
    .st_load(st_load), .st_frame(st_frame),
    .al_load(al_load), .al_frame(al_frame),
    .abort(abort),
    .out_frame(out_frame), .active_src(active_src), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    e = 0; st_start = 0; al_start = 0; st_valid = 0; al_valid = 0;
    m_bg = 64'h0; m_st = 64'h0; m_al = 64'h0;
    pend_out = 64'h0; pend_src = 2'd0; pend_busy = 1'b0;
  endtask

  // Apply the inputs sampled at this edge; what the DUT shows now was decided one edge ago.
  task automatic model_edge();
    bit st_on, al_on;
    cur_out = pend_out; cur_src = pend_src; cur_busy = pend_busy;
    if (bg_load) m_bg = bg_frame;
    if (st_load) begin m_st = st_frame; st_start = e; st_valid = 1; end
    if (al_load) begin m_al = al_frame; al_start = e; al_valid = 1; end
    if (abort) begin st_valid = 0; al_valid = 0; end
    st_on = st_valid && ((e - st_start) < N);
    al_on = al_valid && ((e - al_start) < N);
    pend_busy = st_on || al_on;
    if (al_on) begin
      pend_out = (((e - al_start) % (2 * B)) < B) ? m_al : 64'h0;
      pend_src = 2'd2;
    end else if (st_on) begin
      pend_out = m_st; pend_src = 2'd1;
    end else begin
      pend_out = m_bg; pend_src = 2'd0;
    end
    e++;
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("out_frame", out_frame, cur_out);
    chk("active_src", {62'h0, active_src}, {62'h0, cur_src});
    chk("busy", {63'h0, busy}, {63'h0, cur_busy});
    bg_load = 1'b0; st_load = 1'b0; al_load = 1'b0; abort = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    bg_load = 1'b0; st_load = 1'b0; al_load = 1'b0; abort = 1'b0;
    bg_frame = 64'h0; st_frame = 64'h0; al_frame = 64'h0;
    model_reset();
    #12;
    chk("reset_out", out_frame, 64'h0);
    chk("reset_src", {62'h0, active_src}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    rst_n = 1'b1;

    // background load shows next cycle
    bg_frame = 64'h3F06_5B4F_666D_7D07; bg_load = 1'b1;
    run(2);
    // status hold
    st_frame = 64'h7300; st_load = 1'b1;
    run(14);
    // alert blink over full hold
    al_frame = 64'hFF; al_load = 1'b1;
    run(14);
    // status active, alert, alert retrigger at +10, later status retrigger
    st_frame = 64'h1234; st_load = 1'b1;
    run(1);
    al_frame = 64'hAA; al_load = 1'b1;
    run(10);
    al_frame = 64'hBB; al_load = 1'b1;
    st_frame = 64'h5678; st_load = 1'b1;
    run(16);
    // retrigger on the expiry edge and on the last active edge
    st_frame = 64'h0101; st_load = 1'b1;
    run(N);
    st_frame = 64'h0202; st_load = 1'b1;
    run(N - 1);
    st_frame = 64'h0303; st_load = 1'b1;
    run(N + 2);
    // bg_load during a hold stays hidden until the hold ends
    al_frame = 64'hC0; al_load = 1'b1;
    run(3);
    bg_frame = 64'hDEAD_BEEF; bg_load = 1'b1;
    run(N + 1);
    // simultaneous loads, abort at +5 together with a new alert load
    st_frame = 64'h5555; al_frame = 64'h6666;
    st_load = 1'b1; al_load = 1'b1;
    run(5);
    abort = 1'b1; al_frame = 64'h7777; al_load = 1'b1;
    run(3);
    // asynchronous reset mid-alert
    al_frame = 64'hF0F0; al_load = 1'b1;
    run(5);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out_frame, 64'h0);
    chk("async_rst_src", {62'h0, active_src}, 64'h0);
    chk("async_rst_busy", {63'h0, busy}, 64'h0);
    model_reset();
    #1 rst_n = 1'b1;
    run(N + 4);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bg_frame = {$urandom, $urandom};
      st_frame = {$urandom, $urandom};
      al_frame = {$urandom, $urandom};
      bg_load  = ($urandom_range(0, 7) == 0);
      st_load  = ($urandom_range(0, 9) == 0);
      al_load  = ($urandom_range(0, 13) == 0);
      abort    = ($urandom_range(0, 39) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tub_frame_sched.md
TUB_FRAME_SCHED -- requirements
Module: tub_frame_sched

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000, meaning sys_clk cycles per 1 ms tick.
REQ-002 The block SHALL have parameter HOLD_MS, default 2000, meaning the display time in ms of a status or alert frame.
REQ-003 The block SHALL have parameter BLINK_MS, default 250, meaning the alert half-period in ms.
REQ-004 sys_clk  input  1  system clock, all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 bg_load  input  1  one-cycle strobe that captures bg_frame.
REQ-007 bg_frame  input  64  background frame, digit7 in [63:56] through digit0 in [7:0], active-high segment codes.
REQ-008 st_load  input  1  one-cycle strobe that captures st_frame and starts the status hold.
REQ-009 st_frame  input  64  status frame.
REQ-010 al_load  input  1  one-cycle strobe that captures al_frame and starts the alert hold.
REQ-011 al_frame  input  64  alert frame.
REQ-012 abort  input  1  cancels the status and alert holds.
REQ-013 out_frame  output  64  registered frame to the tube display driver, split into data7..data0.
REQ-014 active_src  output  2  registered source shown: 0 = background, 1 = status, 2 = alert.
REQ-015 busy  output  1  registered, 1 while the status or alert channel is active.

Function
REQ-016 Each source SHALL own a 64-bit frame buffer, written only on the edge where its load is sampled high.
REQ-017 Let N = HOLD_MS*TICK_DIV and B = BLINK_MS*TICK_DIV; each timed channel SHALL have its own cycle counter, so there is no shared free-running prescaler.
REQ-018 If the status or alert load is sampled at edge E, that channel SHALL be active from E through edge E+N-1 and inactive from edge E+N onward.
REQ-019 A load on an already-active channel SHALL restart its counter from zero and replace its buffer (retrigger).
REQ-020 Priority SHALL be: alert active, then status active, then background.
REQ-021 Selection and out_frame SHALL be registered, giving exactly 1 cycle of latency from a channel state change to the outputs.
REQ-022 Alert blink: cycles 0..B-1 of the alert counter SHALL show al_frame, cycles B..2B-1 SHALL show all zeros, and the pattern SHALL repeat until expiry; every alert load starts in the visible phase.
REQ-023 While the alert is in its blank phase, active_src SHALL remain 2.
REQ-024 When the alert expires, output SHALL fall back to status if still active, otherwise to background, without stale data.
REQ-025 Simultaneous st_load and al_load SHALL both be accepted, and alert SHALL be shown.
REQ-026 A bg_load while a timed channel is active SHALL update the buffer only; it SHALL be shown once that channel is inactive.
REQ-027 Load on the same edge as the expiry cycle SHALL act as a retrigger with no gap.
REQ-028 abort sampled high SHALL clear both counters and active flags; outputs SHALL show background one cycle later; abort SHALL win over a same-edge st_load or al_load, and that load's buffer write SHALL still occur.
REQ-029 busy SHALL equal the registered OR of the status and alert active flags.
REQ-030 Counters SHALL saturate at N and never wrap.

Reset
REQ-031 On asserting rst_n low, all buffers, counters, active flags, out_frame = 64'h0, active_src = 0 and busy = 0 SHALL be set immediately, independent of the clock.
REQ-032 After deassertion, the first sampled load SHALL behave exactly per REQ-018.
REQ-033 Reset asserted mid-hold SHALL discard the hold entirely; there is no resume.

Verification (TICK_DIV=4, HOLD_MS=3, BLINK_MS=1, so N=12, B=4)
REQ-034 Reset, then bg_load with 64'h3F06_5B4F_666D_7D07 -> next cycle out_frame equals it, active_src=0, busy=0.
REQ-035 st_load with 64'h7300 at edge E -> active_src=1 and busy=1 from E+1 through E+12; background returns at E+13.
REQ-036 al_load at E with 64'hFF -> out_frame=FF for 4 cycles, then 0 for 4, then FF for 4; active_src=2 throughout; status or background is shown after E+12.
REQ-037 Status active, al_load at E, then al_load retrigger at E+10 -> alert is shown until E+22 in visible phase first; status is shown after that if still active.
REQ-038 Simultaneous st_load and al_load, then abort at E+5 -> background is shown at E+6, busy=0, and both buffers hold the new frames.
REQ-039 rst_n pulsed low mid-alert -> outputs go to 0 immediately, and no alert reappears after release.
